// File: rtl/led_pkg.sv
// Shared definitions for the LED output stage.
//   LED_W    : number of board LEDs driven
//   led_t    : one bit per LED
//   led_off(): pin pattern that leaves every LED dark for a given polarity
package led_pkg;

  localparam int unsigned LED_W = 4;

  typedef logic [LED_W-1:0] led_t;

  function automatic led_t led_off(input logic active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/led_driver_pwm.sv
// Global PWM phase generator for the LED driver.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, clears the counter
//   pwm_on : high while the free-running counter is below DUTY
// PWM_BITS sets the counter width (1..8); DUTY ranges 0..2**PWM_BITS,
// where 0 is always off and 2**PWM_BITS is always on.
module led_pwm #(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned DUTY     = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic pwm_on
);

  // One extra bit so DUTY = 2**PWM_BITS compares as constantly true.
  localparam logic [PWM_BITS:0] DUTY_CMP = (PWM_BITS+1)'(DUTY);

  logic [PWM_BITS-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign pwm_on = ({1'b0, cnt} < DUTY_CMP);

endmodule

// File: rtl/led_driver.sv
// Registered 4-bit LED output stage at the end of the datapath.
//   clk   : system clock
//   rst_n : asynchronous active-low reset; forces out to all-off
//   in    : data word, bit i high means LED i lit
//   err   : error flag (only with LED_ERR_BLINK_EN defined)
//   out   : LED pin drive, polarity set by ACTIVE_LOW
// Two-stage pipeline: in -> in_q -> out. Global PWM dimming via led_pwm.
// Optional feature macro LED_ERR_BLINK_EN: while the registered err is high
// all LEDs flash together from the MSB of a BLINK_DIV-bit counter.
module led_driver
  import led_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned DUTY       = 16
`ifdef LED_ERR_BLINK_EN
  , parameter int unsigned BLINK_DIV = 24
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  led_t in,
`ifdef LED_ERR_BLINK_EN
  input  logic err,
`endif
  output led_t out
);

  led_t in_q;
  led_t lit;
  logic pwm_on;

  led_pwm #(
    .PWM_BITS (PWM_BITS),
    .DUTY     (DUTY)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_on (pwm_on)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= '0;
    else        in_q <= in;
  end

`ifdef LED_ERR_BLINK_EN
  logic                 err_q;
  logic [BLINK_DIV-1:0] blink_cnt;

  // err is registered alongside in so both take effect on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      err_q     <= err;
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    lit = in_q & {LED_W{pwm_on}};
    if (err_q) lit = {LED_W{blink_cnt[BLINK_DIV-1]}} & {LED_W{pwm_on}};
  end
`else
  always_comb begin
    lit = in_q & {LED_W{pwm_on}};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= led_off(ACTIVE_LOW);
    else        out <= ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: tb/tb_led_driver.sv
module tb_led_driver;
  import led_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  led_t in_w;
  led_t out_def, out_al0, out_d8, out_d0;
`ifdef LED_ERR_BLINK_EN
  logic err_w;
  led_t out_blk;
`endif

  always #5 clk = ~clk;

  led_driver u_def (.clk(clk), .rst_n(rst_n), .in(in_w),
`ifdef LED_ERR_BLINK_EN
    .err(1'b0),
`endif
    .out(out_def));

  led_driver #(.ACTIVE_LOW(1'b0)) u_al0 (.clk(clk), .rst_n(rst_n), .in(in_w),
`ifdef LED_ERR_BLINK_EN
    .err(1'b0),
`endif
    .out(out_al0));

  led_driver #(.PWM_BITS(4), .DUTY(8)) u_d8 (.clk(clk), .rst_n(rst_n), .in(in_w),
`ifdef LED_ERR_BLINK_EN
    .err(1'b0),
`endif
    .out(out_d8));

  led_driver #(.PWM_BITS(4), .DUTY(0)) u_d0 (.clk(clk), .rst_n(rst_n), .in(in_w),
`ifdef LED_ERR_BLINK_EN
    .err(1'b0),
`endif
    .out(out_d0));

`ifdef LED_ERR_BLINK_EN
  led_driver #(.BLINK_DIV(4)) u_blk (.clk(clk), .rst_n(rst_n), .in(in_w),
    .err(err_w), .out(out_blk));
`endif

  // Edges seen since the last reset release; stable when sampled at negedge.
  int edge_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  typedef struct {
    int   tgt;
    led_t e_def, e_al0, e_d8, e_d0, e_blk;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input led_t act, input led_t exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %b want %b (edge %0d)", name, act, exp_v, edge_n);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_def"}, out_def, 4'b1111);
    chk({tag, "_al0"}, out_al0, 4'b0000);
    chk({tag, "_d8"},  out_d8,  4'b1111);
    chk({tag, "_d0"},  out_d0,  4'b1111);
`ifdef LED_ERR_BLINK_EN
    chk({tag, "_blk"}, out_blk, 4'b1111);
`endif
  endtask

  // Expected pins at edge tgt for data v / err e applied just before edge tgt-1.
  // Both counters hold tgt-1 when edge tgt computes out.
  function automatic exp_t model(input int tgt, input led_t v, input logic e);
    exp_t x;
    int   c;
    c       = (tgt - 1) % 16;
    x.tgt   = tgt;
    x.e_def = ~v;
    x.e_al0 = v;
    x.e_d8  = (c < 8) ? ~v : 4'b1111;
    x.e_d0  = 4'b1111;
    x.e_blk = e ? ((c >= 8) ? 4'b0000 : 4'b1111) : ~v;
    return x;
  endfunction

  // First edge after release still sees in_q = 0.
  function automatic exp_t first_edge();
    exp_t x;
    x.tgt   = 1;
    x.e_def = 4'b1111;
    x.e_al0 = 4'b0000;
    x.e_d8  = 4'b1111;
    x.e_d0  = 4'b1111;
    x.e_blk = 4'b1111;
    return x;
  endfunction

  task automatic drive(input led_t v, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      in_w = v;
`ifdef LED_ERR_BLINK_EN
      err_w = e;
`endif
      sb.push_back(model(edge_n + 2, v, e));
      @(negedge clk);
    end
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    sb.push_back(first_edge());
  endtask

  // Monitor: every negedge, pop the entry due at this edge and compare.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (sb.size() > 0 && sb[0].tgt < edge_n) begin
          x = sb.pop_front();
          total++;
          bad++;
          $display("FAIL stale_entry: got edge %0d want edge %0d", edge_n, x.tgt);
        end
        if (sb.size() > 0 && sb[0].tgt == edge_n) begin
          x = sb.pop_front();
          chk("def", out_def, x.e_def);
          chk("al0", out_al0, x.e_al0);
          chk("d8",  out_d8,  x.e_d8);
          chk("d0",  out_d0,  x.e_d0);
`ifdef LED_ERR_BLINK_EN
          chk("blk", out_blk, x.e_blk);
`endif
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    in_w  = 4'hF;
`ifdef LED_ERR_BLINK_EN
    err_w = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1 chk_off("por_async");
    repeat (3) @(negedge clk);
    chk_off("rst_hold");

    release_rst();
    drive(4'hF, 1'b0, 4);
    for (int v = 0; v < 16; v++) drive(led_t'(v), 1'b0, 10);

    drive(4'hA, 1'b0, 12);
    #2 rst_n = 1'b0;
    #1 chk_off("mid_rst_async");
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      chk_off("mid_rst_hold");
    end
    release_rst();
    drive(4'hA, 1'b0, 20);

`ifdef LED_ERR_BLINK_EN
    drive(4'h3, 1'b1, 32);
    drive(4'h3, 1'b0, 8);
`endif
    drive(4'h5, 1'b0, 6);

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
